vc_multi_drop_unit: RTL and testbench



---
 rtl/vc_multi_drop_unit_pkg.sv | 22 ++
 rtl/vc_multi_drop_unit_ctr.sv | 45 ++++
 rtl/vc_multi_drop_unit.sv | 97 +++++++++
 tb/tb_vc_multi_drop_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_multi_drop_unit_pkg.sv
// Shared constants, counter-width helper and steering modes for vc_multi_drop_unit.
`default_nettype none

package vc_multi_drop_unit_pkg;

    // Default message width: VC_MEM_RESP_MSG_NBITS(8,32).
    localparam int C_DEFAULT_MSG_NBITS = 45;

    function automatic int ctr_nbits(input int max_drops);
        return $clog2(max_drops + 1);
    endfunction

    typedef enum logic [1:0] {
        STEER_RESET  = 2'd0,
        STEER_PASS   = 2'd1,
        STEER_DROP   = 2'd2,
        STEER_DOMAIN = 2'd3
    } steer_e;

endpackage

`default_nettype wire

// File: rtl/vc_multi_drop_unit_ctr.sv
// Saturating pending-drop counter with a sticky overflow flag.
`default_nettype none

module vc_multi_drop_unit_ctr
    import vc_multi_drop_unit_pkg::*;
#(
    parameter int p_max_drops = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               inc,
    input  logic                               dec,
    output logic [ctr_nbits(p_max_drops)-1:0]  count,
    output logic                               sat,
    output logic                               overflow
);

    localparam int C_W = ctr_nbits(p_max_drops);
    localparam logic [C_W-1:0] C_MAX = C_W'(p_max_drops);

    logic [C_W-1:0] r_count;
    logic           r_overflow;

    assign sat      = (r_count == C_MAX);
    assign count    = r_count;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (inc && !dec) begin
            // A drop arriving at saturation is lost; remember that it happened.
            if (sat)
                r_overflow <= 1'b1;
            else
                r_count <= r_count + C_W'(1);
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - C_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/vc_multi_drop_unit.sv
// Squashes up to p_max_drops stale imem responses; optional domain-tag check
// enabled by defining VC_MULTI_DROP_UNIT_DOMAIN_CHECK_EN.
`default_nettype none

module vc_multi_drop_unit
    import vc_multi_drop_unit_pkg::*;
#(
    parameter int p_msg_nbits = C_DEFAULT_MSG_NBITS,
    parameter int p_max_drops = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               drop,
    input  logic [p_msg_nbits-1:0]             in_msg,
    input  logic                               in_val,
    output logic                               in_rdy,
    output logic [p_msg_nbits-1:0]             out_msg,
    output logic                               out_val,
    input  logic                               out_rdy,
    input  logic                               in_domain,
    input  logic                               exp_domain,
    output logic [ctr_nbits(p_max_drops)-1:0]  pending,
    output logic                               overflow,
    output logic                               domain_viol
);

    localparam int C_W = ctr_nbits(p_max_drops);

    logic [C_W:0] w_eff;
    logic         w_domain_bad;
    logic         w_inc;
    logic         w_dec;
    logic         w_sat_unused;
    steer_e       w_steer;

    assign out_msg = in_msg;
    assign w_eff   = {1'b0, pending} + {{C_W{1'b0}}, drop};

`ifdef VC_MULTI_DROP_UNIT_DOMAIN_CHECK_EN
    assign w_domain_bad = in_val && (in_domain != exp_domain);
`else
    logic w_domain_unused;
    assign w_domain_unused = in_domain ^ exp_domain;
    assign w_domain_bad    = 1'b0;
`endif

    // A same-cycle drop and response cancel: the response dies, the count holds.
    assign w_inc = drop && !in_val;
    assign w_dec = !drop && in_val && (pending != '0);

    vc_multi_drop_unit_ctr #(
        .p_max_drops (p_max_drops)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_inc),
        .dec      (w_dec),
        .count    (pending),
        .sat      (w_sat_unused),
        .overflow (overflow)
    );

    always_comb begin
        w_steer     = STEER_PASS;
        out_val     = 1'b0;
        in_rdy      = 1'b0;
        domain_viol = 1'b0;

        if (reset)
            w_steer = STEER_RESET;
        else if (w_eff != '0)
            w_steer = STEER_DROP;
        else if (w_domain_bad)
            w_steer = STEER_DOMAIN;

        case (w_steer)
            STEER_PASS: begin
                out_val = in_val;
                in_rdy  = out_rdy;
            end
            STEER_DROP: begin
                in_rdy = 1'b1;
            end
            STEER_DOMAIN: begin
                in_rdy      = 1'b1;
                domain_viol = 1'b1;
            end
            default: begin
                out_val = 1'b0;
                in_rdy  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_vc_multi_drop_unit.sv
// Directed self-checking bench for vc_multi_drop_unit (p_max_drops = 4).
`default_nettype none

module tb_vc_multi_drop_unit;

    localparam int MSG_W = 45;

    logic             clk = 1'b0;
    logic             reset;
    logic             drop;
    logic [MSG_W-1:0] in_msg;
    logic             in_val;
    logic             in_rdy;
    logic [MSG_W-1:0] out_msg;
    logic             out_val;
    logic             out_rdy;
    logic             in_domain;
    logic             exp_domain;
    logic [2:0]       pending;
    logic             overflow;
    logic             domain_viol;

    int n_cmp  = 0;
    int n_fail = 0;

    vc_multi_drop_unit #(
        .p_msg_nbits (MSG_W),
        .p_max_drops (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .drop        (drop),
        .in_msg      (in_msg),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .out_msg     (out_msg),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .in_domain   (in_domain),
        .exp_domain  (exp_domain),
        .pending     (pending),
        .overflow    (overflow),
        .domain_viol (domain_viol)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drop   = 1'b0;
        in_val = 1'b0;
    endtask

    initial begin
        logic [MSG_W-1:0] exp_msg;
        int               delivered;
        int               cycles;

        reset      = 1'b1;
        drop       = 1'b0;
        in_msg     = '0;
        in_val     = 1'b1;
        out_rdy    = 1'b1;
        in_domain  = 1'b0;
        exp_domain = 1'b0;
        step();
        step();
        #1;
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_viol", 64'(domain_viol), 64'd0);
        reset = 1'b0;
        idle();
        step();

        // Pass-through: 8 responses in order under random backpressure.
        delivered = 0;
        cycles    = 0;
        while (delivered < 8 && cycles < 200) begin
            exp_msg = MSG_W'(45'h100 + delivered);
            in_msg  = exp_msg;
            in_val  = 1'b1;
            out_rdy = 1'($urandom_range(0, 1));
            #1;
            check("pass_out_val", 64'(out_val), 64'd1);
            check("pass_in_rdy", 64'(in_rdy), 64'(out_rdy));
            check("pass_out_msg", 64'(out_msg), 64'(exp_msg));
            if (out_rdy) delivered++;
            cycles++;
            step();
        end
        check("pass_count", 64'(delivered), 64'd8);
        check("pass_pending", 64'(pending), 64'd0);
        idle();
        out_rdy = 1'b1;
        step();

        // Burst squash: 3 drops, then 4 responses; only the 4th passes.
        drop = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("burst_pend_up", 64'(pending), 64'(i));
        end
        drop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_msg = MSG_W'(45'h200 + i);
            in_val = 1'b1;
            #1;
            check("burst_out_val", 64'(out_val), 64'd0);
            check("burst_in_rdy", 64'(in_rdy), 64'd1);
            step();
            check("burst_pend_dn", 64'(pending), 64'(2 - i));
        end
        in_msg = MSG_W'(45'h203);
        #1;
        check("burst_4th_val", 64'(out_val), 64'd1);
        check("burst_4th_msg", 64'(out_msg), 64'h203);
        step();
        idle();

        // Same-cycle squash with nothing pending.
        drop   = 1'b1;
        in_val = 1'b1;
        #1;
        check("same_in_rdy", 64'(in_rdy), 64'd1);
        check("same_out_val", 64'(out_val), 64'd0);
        step();
        check("same_pending", 64'(pending), 64'd0);

        // Response stalled by out_rdy=0 is squashed when drop arrives.
        drop    = 1'b0;
        out_rdy = 1'b0;
        #1;
        check("stall_out_val", 64'(out_val), 64'd1);
        check("stall_in_rdy", 64'(in_rdy), 64'd0);
        step();
        drop = 1'b1;
        #1;
        check("stall_sq_val", 64'(out_val), 64'd0);
        check("stall_sq_rdy", 64'(in_rdy), 64'd1);
        step();
        check("stall_sq_pend", 64'(pending), 64'd0);
        idle();
        out_rdy = 1'b1;

        // Drop plus response while one drop already pends: count holds at 1.
        drop = 1'b1;
        step();
        check("hold_pend1", 64'(pending), 64'd1);
        in_val = 1'b1;
        #1;
        check("hold_out_val", 64'(out_val), 64'd0);
        step();
        check("hold_pend_same", 64'(pending), 64'd1);
        drop = 1'b0;
        step();
        check("hold_pend_clr", 64'(pending), 64'd0);
        idle();

        // Saturation: 6 drops cap at 4 and set overflow; 5th response passes.
        drop = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("sat_pend", 64'(pending), 64'((i > 4) ? 4 : i));
            check("sat_ovf", 64'(overflow), 64'((i > 4) ? 1 : 0));
        end
        drop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_msg = MSG_W'(45'h300 + i);
            in_val = 1'b1;
            #1;
            check("sat_disc_val", 64'(out_val), 64'd0);
            step();
            check("sat_pend_dn", 64'(pending), 64'(3 - i));
        end
        in_msg = MSG_W'(45'h304);
        #1;
        check("sat_5th_val", 64'(out_val), 64'd1);
        check("sat_5th_msg", 64'(out_msg), 64'h304);
        check("sat_ovf_sticky", 64'(overflow), 64'd1);
        step();
        idle();

        // Reset mid-operation clears the count and overflow.
        drop = 1'b1;
        step();
        step();
        check("mid_pend2", 64'(pending), 64'd2);
        drop   = 1'b0;
        reset  = 1'b1;
        in_val = 1'b1;
        in_msg = MSG_W'(45'h400);
        #1;
        check("mid_rst_rdy", 64'(in_rdy), 64'd0);
        check("mid_rst_val", 64'(out_val), 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("mid_pend0", 64'(pending), 64'd0);
        check("mid_ovf0", 64'(overflow), 64'd0);
        check("mid_fwd_val", 64'(out_val), 64'd1);
        check("mid_fwd_msg", 64'(out_msg), 64'h400);
        step();
        idle();

        // Domain mismatch in pass mode.
        exp_domain = 1'b1;
        in_domain  = 1'b0;
        in_val     = 1'b1;
        in_msg     = MSG_W'(45'h500);
        #1;
`ifdef VC_MULTI_DROP_UNIT_DOMAIN_CHECK_EN
        check("dom_out_val", 64'(out_val), 64'd0);
        check("dom_in_rdy", 64'(in_rdy), 64'd1);
        check("dom_viol", 64'(domain_viol), 64'd1);
`else
        check("dom_out_val", 64'(out_val), 64'd1);
        check("dom_in_rdy", 64'(in_rdy), 64'd1);
        check("dom_viol", 64'(domain_viol), 64'd0);
`endif
        step();
        check("dom_pending", 64'(pending), 64'd0);
        in_domain = 1'b1;
        #1;
        check("dom_match_val", 64'(out_val), 64'd1);
        check("dom_viol_clr", 64'(domain_viol), 64'd0);
        step();
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
